// File: rtl/spi_flash_pkg.sv
// Shared constants and FSM encoding for the boot SPI flash read controller.
// FLASH_FAST_READ_EN selects fast read (opcode 0x0B plus a dummy byte); default build is plain read.
package spi_flash_pkg;

    localparam int ADDR_W = 24;
    localparam int LEN_W  = 8;

    localparam logic [7:0] FLASH_OP_READ      = 8'h03;
    localparam logic [7:0] FLASH_OP_FAST_READ = 8'h0B;

`ifdef FLASH_FAST_READ_EN
    localparam logic [7:0] FLASH_OPCODE = FLASH_OP_FAST_READ;
`else
    localparam logic [7:0] FLASH_OPCODE = FLASH_OP_READ;
`endif

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_ADDR,
`ifdef FLASH_FAST_READ_EN
        ST_DUMMY,
`endif
        ST_DATA,
        ST_HOLD
    } state_t;

endpackage

// File: rtl/spi_flash_phy.sv
// SPI mode-0 bit engine: SCK half-period pacing, MOSI shift-out on falling SCK, MISO shift-in on rising SCK.
// A rising edge that is due while stretch is high is held off, keeping SCK low until stretch drops.
module spi_flash_phy #(
    parameter int CLK_DIV = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        run,
    input  logic        stretch,
    input  logic        load,
    input  logic [31:0] tx_word,
    input  logic        miso,
    output logic        sck,
    output logic        mosi,
    output logic        due,
    output logic        rise,
    output logic [7:0]  rx_next
);

    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] DIV_LAST = CW'(CLK_DIV - 1);

    logic [CW-1:0] cnt;
    logic [31:0]   tx_sr;
    logic [6:0]    rx_sr;
    logic          at_edge;
    logic          fall;

    assign at_edge = run && (cnt == DIV_LAST);
    assign due     = at_edge && !sck;
    assign rise    = due && !stretch;
    assign fall    = at_edge && sck;
    assign mosi    = tx_sr[31];
    assign rx_next = {rx_sr, miso};

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt   <= '0;
            sck   <= 1'b0;
            tx_sr <= '0;
            rx_sr <= '0;
        end else begin
            if (!run) begin
                cnt <= '0;
                sck <= 1'b0;
            end else if (at_edge) begin
                if (sck || !stretch) begin
                    cnt <= '0;
                    sck <= !sck;
                end
            end else begin
                cnt <= cnt + CW'(1);
            end
            // Zeros trail the opcode/address, so MOSI rests low through dummy and data phases.
            if (load) begin
                tx_sr <= tx_word;
            end else if (fall) begin
                tx_sr <= {tx_sr[30:0], 1'b0};
            end
            if (rise) begin
                rx_sr <= rx_next[6:0];
            end
        end
    end

endmodule

// File: rtl/spi_flash_rd_ctrl.sv
// Boot SPI flash read sequencer: opcode, 24-bit address, optional dummy byte (FLASH_FAST_READ_EN), data bytes out on valid/ready.
// First byte 2+(2*39+1)*CLK_DIV cycles after accept; a stalled consumer stretches SCK low before the next byte's last bit.
import spi_flash_pkg::*;

module spi_flash_rd_ctrl #(
    parameter int CLK_DIV = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [LEN_W-1:0]  req_len,
    output logic              rd_valid,
    input  logic              rd_ready,
    output logic [7:0]        rd_data,
    output logic              rd_last,
    output logic              busy,
    output logic              flash_ss,
    output logic              flash_sck,
    output logic              flash_mosi,
    input  logic              flash_miso
);

    localparam int HW = $clog2(2 * CLK_DIV);
    localparam logic [HW-1:0] HOLD_LAST = HW'(2 * CLK_DIV - 1);

    state_t           state;
    state_t           next_state;
    logic             run;
    logic             due;
    logic             rise;
    logic             stretch;
    logic             accept;
    logic             data_sample;
    logic [4:0]       bit_cnt;
    logic [LEN_W-1:0] byte_cnt;
    logic [LEN_W-1:0] len_q;
    logic             done_q;
    logic             pend;
    logic             last_pend;
    logic [HW-1:0]    hold_cnt;
    logic [7:0]       rx_next;

    assign accept      = req_valid && (state == ST_IDLE);
    assign data_sample = (state == ST_DATA) && rise && (bit_cnt[2:0] == 3'd7);
    // After the last sample, the trailing low half-period runs out before CS rises.
    assign stretch     = (state == ST_DATA) &&
                         (done_q || ((bit_cnt[2:0] == 3'd7) && rd_valid && !rd_ready));

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE: if (req_valid) next_state = ST_CMD;
            ST_CMD:  if (rise && bit_cnt == 5'd7) next_state = ST_ADDR;
`ifdef FLASH_FAST_READ_EN
            ST_ADDR:  if (rise && bit_cnt == 5'd23) next_state = ST_DUMMY;
            ST_DUMMY: if (rise && bit_cnt == 5'd7) next_state = ST_DATA;
`else
            ST_ADDR:  if (rise && bit_cnt == 5'd23) next_state = ST_DATA;
`endif
            ST_DATA: if (done_q && due) next_state = ST_HOLD;
            ST_HOLD: if (hold_cnt == HOLD_LAST) next_state = ST_IDLE;
            default: next_state = ST_IDLE;
        endcase
    end

    always_comb begin
        req_ready = 1'b0;
        busy      = 1'b1;
        flash_ss  = 1'b0;
        run       = 1'b1;
        case (state)
            ST_IDLE: begin
                req_ready = 1'b1;
                busy      = 1'b0;
                flash_ss  = 1'b1;
                run       = 1'b0;
            end
            ST_HOLD: begin
                flash_ss = 1'b1;
                run      = 1'b0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bit_cnt   <= '0;
            byte_cnt  <= '0;
            len_q     <= '0;
            done_q    <= 1'b0;
            pend      <= 1'b0;
            last_pend <= 1'b0;
            hold_cnt  <= '0;
            rd_valid  <= 1'b0;
            rd_last   <= 1'b0;
            rd_data   <= '0;
        end else begin
            if (state != next_state) begin
                bit_cnt <= '0;
            end else if (rise) begin
                bit_cnt <= bit_cnt + 5'd1;
            end
            hold_cnt <= (state == ST_HOLD) ? hold_cnt + HW'(1) : '0;
            if (accept) begin
                len_q    <= req_len;
                byte_cnt <= '0;
                done_q   <= 1'b0;
            end
            pend <= data_sample;
            if (data_sample) begin
                rd_data   <= rx_next;
                last_pend <= (byte_cnt == len_q);
                done_q    <= (byte_cnt == len_q);
                byte_cnt  <= byte_cnt + 8'd1;
            end
            if (pend) begin
                rd_valid <= 1'b1;
                rd_last  <= last_pend;
            end else if (rd_valid && rd_ready) begin
                rd_valid <= 1'b0;
                rd_last  <= 1'b0;
            end
        end
    end

    spi_flash_phy #(
        .CLK_DIV (CLK_DIV)
    ) u_phy (
        .clk     (clk),
        .rst     (rst),
        .run     (run),
        .stretch (stretch),
        .load    (accept),
        .tx_word ({FLASH_OPCODE, req_addr}),
        .miso    (flash_miso),
        .sck     (flash_sck),
        .mosi    (flash_mosi),
        .due     (due),
        .rise    (rise),
        .rx_next (rx_next)
    );

endmodule

// File: tb/tb_spi_flash_rd_ctrl.sv
// Directed bench for spi_flash_rd_ctrl with a behavioural flash that returns base+byte_index; honours FLASH_FAST_READ_EN.
module tb_spi_flash_rd_ctrl;

    localparam int CLK_DIV = 2;
`ifdef FLASH_FAST_READ_EN
    localparam int PRE       = 40;
    localparam int EXP_OP    = 8'h0B;
    localparam int FIRST_LAT = 192;
    localparam int B2B_DELTA = 199;
    localparam int NV        = 2;
`else
    localparam int PRE       = 32;
    localparam int EXP_OP    = 8'h03;
    localparam int FIRST_LAT = 160;
    localparam int B2B_DELTA = 167;
    localparam int NV        = 4;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [23:0] req_addr;
    logic [7:0]  req_len;
    logic        rd_valid;
    logic        rd_ready;
    logic [7:0]  rd_data;
    logic        rd_last;
    logic        busy;
    logic        flash_ss;
    logic        flash_sck;
    logic        flash_mosi;
    logic        flash_miso;

    spi_flash_rd_ctrl #(.CLK_DIV(CLK_DIV)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_addr   (req_addr),
        .req_len    (req_len),
        .rd_valid   (rd_valid),
        .rd_ready   (rd_ready),
        .rd_data    (rd_data),
        .rd_last    (rd_last),
        .busy       (busy),
        .flash_ss   (flash_ss),
        .flash_sck  (flash_sck),
        .flash_mosi (flash_mosi),
        .flash_miso (flash_miso)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int          checks = 0;
    int          failures = 0;

    // Flash model: counts SCK rises, captures the first 40 MOSI bits, serves base+j on MISO.
    int          m_n = 0;
    int          m_last_n = 0;
    logic [39:0] m_cmd = '0;
    logic [7:0]  m_base = '0;
    logic        m_prev_sck = 1'b0;

    always @(negedge clk) begin : model
        logic [7:0] mb;
        int         j;
        if (flash_ss) begin
            if (m_n != 0) m_last_n = m_n;
            m_n = 0;
            m_prev_sck = 1'b0;
        end else begin
            if (flash_sck && !m_prev_sck) begin
                if (m_n == 0) m_cmd = '0;
                if (m_n < 40) m_cmd[39-m_n] = flash_mosi;
                m_n++;
            end
            m_prev_sck = flash_sck;
        end
        if (m_n >= PRE) begin
            j = m_n - PRE;
            mb = m_base + 8'(j / 8);
            flash_miso = mb[7-(j%8)];
        end else begin
            flash_miso = 1'b1;
        end
    end

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", nm, act, exp);
        end
    endtask

    int t_acc, t_first, t_ss, t_rdy;
    int n_hs, n_last, last_idx, bad_data, bad_space, max_low, n_at_stretch, unstable;

    task automatic run_read(input logic [23:0] addr, input logic [7:0] len,
                            input logic [7:0] base, input bit stall);
        bit         acc;
        bit         fin;
        logic       pv;
        logic       pr;
        logic [7:0] pd;
        logic [7:0] exp_b;
        int         low_run;
        int         prev_hs;
        t_acc = -1; t_first = -1; t_ss = -1; t_rdy = -1;
        n_hs = 0; n_last = 0; last_idx = -1; bad_data = 0; bad_space = 0;
        max_low = 0; n_at_stretch = -1; unstable = 0;
        low_run = 0; prev_hs = 0; pv = 1'b0; pr = 1'b0; pd = '0;
        m_base = base;
        rd_ready = !stall;
        @(negedge clk);
        req_addr = addr;
        req_len = len;
        req_valid = 1'b1;
        acc = 1'b0;
        for (int i = 0; i < 50 && !acc; i++) begin
            if (req_ready) begin
                acc = 1'b1;
                t_acc = cyc;
            end else begin
                @(negedge clk);
            end
        end
        @(negedge clk);
        req_valid = 1'b0;
        if (!acc) begin
            chk("accept_timeout", 0, 1);
            return;
        end
        fin = 1'b0;
        for (int i = 0; i < 20000 && !fin; i++) begin
            if (stall && t_first >= 0 && cyc >= t_first + 100) rd_ready = 1'b1;
            if (rd_valid && t_first < 0) t_first = cyc;
            if (pv && !pr && rd_valid && rd_data !== pd) unstable++;
            if (rd_valid && rd_ready) begin
                exp_b = base + 8'(n_hs);
                if (rd_data !== exp_b) bad_data++;
                if (rd_last) begin
                    n_last++;
                    last_idx = n_hs;
                end
                if (n_hs > 0 && cyc - prev_hs != 32) bad_space++;
                prev_hs = cyc;
                n_hs++;
            end
            pv = rd_valid;
            pr = rd_ready;
            pd = rd_data;
            if (flash_ss && t_ss < 0) t_ss = cyc;
            if (!flash_ss && !flash_sck) low_run++; else low_run = 0;
            if (low_run > max_low) max_low = low_run;
            if (low_run == CLK_DIV + 1) n_at_stretch = m_n;
            if (req_ready) begin
                t_rdy = cyc;
                fin = 1'b1;
            end else begin
                @(negedge clk);
            end
        end
        if (!fin) chk("done_timeout", 0, 1);
    endtask

    typedef struct {
        logic [23:0] addr;
        logic [7:0]  len;
        logic [7:0]  base;
        int          t_valid;
        int          t_ss;
        int          t_rdy;
    } vec_t;

    vec_t vecs[NV];

    initial begin
        int acc_cnt, t_a1, t_a2, hr, gap;
        bit seen_low, fin;
`ifdef FLASH_FAST_READ_EN
        vecs[0] = '{24'h000000, 8'd1, 8'h5A, 192, 227, 231};
        vecs[1] = '{24'h123456, 8'd0, 8'hA5, 192, 195, 199};
`else
        vecs[0] = '{24'h123456, 8'd0,   8'hA5, 160, 163,  167};
        vecs[1] = '{24'hABCDEF, 8'd3,   8'h10, 160, 259,  263};
        vecs[2] = '{24'hFFFFFF, 8'd1,   8'hFE, 160, 195,  199};
        vecs[3] = '{24'h000000, 8'd255, 8'h00, 160, 8323, 8327};
`endif
        rst = 1'b1; req_valid = 1'b0; req_addr = '0; req_len = '0; rd_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_ss", int'(flash_ss), 1);
        chk("rst_sck", int'(flash_sck), 0);
        chk("rst_mosi", int'(flash_mosi), 0);
        chk("rst_req_ready", int'(req_ready), 1);
        chk("rst_rd_valid", int'(rd_valid), 0);
        chk("rst_rd_last", int'(rd_last), 0);
        chk("rst_rd_data", int'(rd_data), 0);
        chk("rst_busy", int'(busy), 0);
        rst = 1'b0;

        for (int v = 0; v < NV; v++) begin
            run_read(vecs[v].addr, vecs[v].len, vecs[v].base, 1'b0);
            chk($sformatf("v%0d_opcode", v), int'(m_cmd[39:32]), EXP_OP);
            chk($sformatf("v%0d_addr", v), int'(m_cmd[31:8]), int'(vecs[v].addr));
            chk($sformatf("v%0d_mosi_tail", v), int'(m_cmd[7:0]), 0);
            chk($sformatf("v%0d_sck_rises", v), m_last_n, PRE + 8 * (int'(vecs[v].len) + 1));
            chk($sformatf("v%0d_bytes", v), n_hs, int'(vecs[v].len) + 1);
            chk($sformatf("v%0d_bad_data", v), bad_data, 0);
            chk($sformatf("v%0d_last_count", v), n_last, 1);
            chk($sformatf("v%0d_last_index", v), last_idx, int'(vecs[v].len));
            chk($sformatf("v%0d_first_valid", v), t_first - t_acc, vecs[v].t_valid);
            chk($sformatf("v%0d_ss_rise", v), t_ss - t_acc, vecs[v].t_ss);
            chk($sformatf("v%0d_ready_rise", v), t_rdy - t_acc, vecs[v].t_rdy);
            chk($sformatf("v%0d_spacing", v), bad_space, 0);
            chk($sformatf("v%0d_sck_low_max", v), max_low, CLK_DIV);
        end

        // Consumer stalls 100 cycles from the first byte: byte 2's last bit must wait.
        run_read(24'h0F0F0F, 8'd3, 8'h40, 1'b1);
        chk("stall_bytes", n_hs, 4);
        chk("stall_bad_data", bad_data, 0);
        chk("stall_last_index", last_idx, 3);
        chk("stall_last_count", n_last, 1);
        chk("stall_unstable", unstable, 0);
        chk("stall_stretched", int'(max_low > CLK_DIV), 1);
        chk("stall_stretch_bit", n_at_stretch, PRE + 15);
        chk("stall_first_valid", t_first - t_acc, FIRST_LAT);

        // Reset pulsed in the address phase, then a clean read.
        m_base = 8'h33;
        @(negedge clk);
        req_addr = 24'h654321; req_len = 8'd2; req_valid = 1'b1;
        fin = 1'b0;
        for (int i = 0; i < 50 && !fin; i++) begin
            if (req_ready) fin = 1'b1;
            @(negedge clk);
        end
        req_valid = 1'b0;
        repeat (40) @(negedge clk);
        chk("mid_busy", int'(busy), 1);
        chk("mid_ss", int'(flash_ss), 0);
        rst = 1'b1;
        @(negedge clk);
        chk("arst_ss", int'(flash_ss), 1);
        chk("arst_sck", int'(flash_sck), 0);
        chk("arst_req_ready", int'(req_ready), 1);
        chk("arst_busy", int'(busy), 0);
        chk("arst_rd_valid", int'(rd_valid), 0);
        chk("arst_mosi", int'(flash_mosi), 0);
        rst = 1'b0;
        run_read(24'h000100, 8'd1, 8'h77, 1'b0);
        chk("post_rst_addr", int'(m_cmd[31:8]), 24'h000100);
        chk("post_rst_bytes", n_hs, 2);
        chk("post_rst_bad_data", bad_data, 0);
        chk("post_rst_last_index", last_idx, 1);
        chk("post_rst_first_valid", t_first - t_acc, FIRST_LAT);

        // req_valid held across two requests.
        rd_ready = 1'b1; m_base = 8'h90;
        @(negedge clk);
        req_addr = 24'h111111; req_len = 8'd0; req_valid = 1'b1;
        acc_cnt = 0; t_a1 = 0; t_a2 = 0; hr = 0; gap = -1; seen_low = 1'b0; fin = 1'b0;
        for (int i = 0; i < 1000 && !fin; i++) begin
            if (acc_cnt == 1) req_addr = 24'h222222;
            if (acc_cnt == 2) req_valid = 1'b0;
            if (req_valid && req_ready) begin
                acc_cnt++;
                if (acc_cnt == 1) t_a1 = cyc; else t_a2 = cyc;
            end
            if (flash_ss) begin
                hr++;
            end else begin
                if (seen_low && hr > 0) gap = hr;
                seen_low = 1'b1;
                hr = 0;
            end
            if (acc_cnt == 2 && !req_valid && req_ready) fin = 1'b1;
            else @(negedge clk);
        end
        if (!fin) chk("b2b_timeout", 0, 1);
        chk("b2b_accepts", acc_cnt, 2);
        chk("b2b_second_accept", t_a2 - t_a1, B2B_DELTA);
        chk("b2b_ss_gap_ge4", int'(gap >= 4), 1);
        chk("b2b_second_addr", int'(m_cmd[31:8]), 24'h222222);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
